c1_input_sampler: RTL and testbench
===================================

// Module: c1_input_sampler
// PURPOSE
//  Parametrised, clocked successor to the C1 player-input read path. Synchronises and debounces
//  NUM_PLAYERS active-low controller ports, then drives registered bytes onto M68K_DATA[15:8]
//  for the REG_P1CNT/P2CNT/.. zones and REG_STATUS_B, with an explicit output enable instead of
//  tri-states. Sits between the raw MiSTer joystick inputs and the 68K data bus mux.
// PARAMETERS
//  NUM_PLAYERS  2   controller channels, legal range 2..4; status byte always carries players 0,1
//  BTN_W        10  bits per channel: [7:0] go to the CTRL byte, [9:8] go to STATUS_B
//  DEB_CYCLES   16  CE ticks an input change must stay steady before acceptance, >=1
// PORTS
//  CLK            in   1              system clock
//  nRESET         in   1              asynchronous active-low reset
//  CE             in   1              debounce sample tick, e.g. 1 kHz strobe, one CLK wide
//  P_IN           in   NUM_PLAYERS*BTN_W  raw inputs, active-low, player p at [p*BTN_W +: BTN_W]
//  nCTRL_ZONE     in   NUM_PLAYERS    active-low read select per player CTRL register
//  nSTATUSB_ZONE  in   1              active-low read select for REG_STATUS_B
//  nWP,nCD2,nCD1  in   1 each         memory-card status, passed through 2FF sync only
//  SYSTEM_MODE    in   1              static system-mode bit, sync 2FF
//  M68K_DATA      out  8              read byte for bus [15:8]
//  DATA_OE        out  1              1 = block is driving M68K_DATA
// BEHAVIOUR
//  - Reset (async): sync stages, candidate and stable regs = all 1s (released); counters = 0;
//    M68K_DATA = 8'hFF; DATA_OE = 0; sticky latches, if present, = 0.
//  - Sync: every P_IN, card and mode bit goes through a 2-FF synchroniser, 2 CLK latency.
//  - Debounce, per channel, on the whole BTN_W vector:
//    * sync != cand: cand <= sync, cnt <= 0. This has priority over CE.
//    * else if cand != stable and CE: cnt++; when cnt == DEB_CYCLES-1, stable <= cand, cnt <= 0.
//    * else if cand == stable: cnt <= 0.
//    * A steady change is accepted on exactly the DEB_CYCLES-th CE after it appears at sync.
//      A bounce restarts the count. cnt width is $clog2(DEB_CYCLES+1) and never wraps.
//  - Read path, registered, 1 CLK latency from zone assertion:
//    * DATA_OE <= ~nSTATUSB_ZONE | ~&nCTRL_ZONE.
//    * Data priority when zones overlap: STATUS_B, then CTRL0, then CTRL1, and so on up to
//      the highest index.
//    * STATUS_B = {SYSTEM_MODE, nWP, nCD2, nCD1, stable1[9:8], stable0[9:8]}.
//    * CTRLp = stable_p[7:0].
//    * No zone active: M68K_DATA <= 8'hFF, DATA_OE <= 0.
//  - Reset asserted mid-read: outputs return to reset values immediately.
// CONFIGURATION
//  C1_PRESS_LATCH_EN defined:
//    - Per channel, an 8-bit sticky latch sets on each debounced 1->0 edge of stable_p[7:0].
//    - A CTRLp read returns stable_p[7:0] & ~sticky_p, so a short press is never missed between
//      two polls.
//    - sticky_p clears on the rising edge of nCTRL_ZONE[p], i.e. at end of read.
//    - A press edge in the same cycle as the clear: set wins.
//  C1_PRESS_LATCH_EN undefined: no latch logic; a CTRLp read returns stable_p[7:0] only.
// STRUCTURE
//  - Package c1_inputs_pkg holds:
//    * STATUS_B bit-position localparams.
//    * RELEASED_BYTE = 8'hFF.
//    * typedef btn_vec_t [BTN_W-1:0].
//    * Function deb_cnt_w(DEB_CYCLES).
//  - Sub-module c1_debounce: one per channel via generate. Holds sync, cand, cnt and stable, and
//    outputs stable plus a press-edge vector. The top holds the zone mux, output regs and
//    optional sticky latches.
// TESTING  (NUM_PLAYERS=2, BTN_W=10, DEB_CYCLES=4, CE every 8 CLK)
//  1. Reset, no stimulus, assert nCTRL_ZONE[0] -> after 1 CLK, DATA_OE=1 and M68K_DATA=8'hFF.
//     Reset asserted during the read -> DATA_OE=0 at once.
//  2. P_IN[0] 1->0 held steady -> CTRL0 reads bit0=0 only after the 4th CE past sync. Read
//     after the 3rd CE -> 8'hFF.
//  3. P_IN[0] toggles every 5 CLK for 100 CLK, then settles at 1 -> CTRL0 never shows bit0=0
//     (bounce rejected).
//  4. P_IN[9:8]=2'b01 on player 0, P_IN[19:18]=2'b10 on player 1, nWP=0, nCD2=1, nCD1=1,
//     SYSTEM_MODE=1 -> STATUS_B = 8'b1011_1001.
//  5. nSTATUSB_ZONE and nCTRL_ZONE[1] both low -> STATUS_B byte is returned. nCTRL_ZONE[0] and
//     nCTRL_ZONE[1] both low -> CTRL0 is returned.
//  6. With C1_PRESS_LATCH_EN: press bit3 on player 1 for 5 CE, release, then read CTRL1 ->
//     8'hF7. A second read -> 8'hFF. Without the macro, the same stimulus -> the first read is
//     8'hFF.

Source files
------------

// File: rtl/c1_inputs_pkg.sv
// Shared constants, types and helpers for the C1 player-input sampler.
package c1_inputs_pkg;

  localparam int unsigned BtnW = 10;

  // STATUS_B byte layout on M68K_DATA[15:8]
  localparam int unsigned StbMode = 7;
  localparam int unsigned StbNwp  = 6;
  localparam int unsigned StbNcd2 = 5;
  localparam int unsigned StbNcd1 = 4;
  localparam int unsigned StbP1Lo = 2;
  localparam int unsigned StbP0Lo = 0;

  localparam logic [7:0] RELEASED_BYTE = 8'hFF;

  typedef logic [BtnW-1:0] btn_vec_t;

  // Counter width; the counter only ever reaches cycles-1 and never wraps.
  function automatic int unsigned deb_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/c1_debounce.sv
// One controller channel: 2-FF synchroniser, whole-vector debounce, and a 1->0 press-edge pulse.
module c1_debounce
  import c1_inputs_pkg::*;
#(
  parameter int unsigned BTN_W      = 10,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [BTN_W-1:0] raw_i,
  output logic [BTN_W-1:0] stable_o,
  output logic [BTN_W-1:0] press_o
);

  localparam int unsigned CntW = deb_cnt_w(DEB_CYCLES);

  logic [BTN_W-1:0] sync1_q, sync2_q;
  logic [BTN_W-1:0] cand_q, cand_d;
  logic [BTN_W-1:0] stable_q, stable_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != cand_q) begin
      // Any movement at the synchroniser restarts the count, even on a CE tick.
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q) begin
      if (ce_i) begin
        if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
          stable_d = cand_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      cand_q   <= '1;
      stable_q <= '1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  // Fires in the cycle before stable_q falls, so a latch sets on the same edge.
  assign press_o  = stable_q & ~stable_d;

endmodule

// File: rtl/c1_input_sampler.sv
// C1 player-input read path: debounced controller bytes and STATUS_B onto M68K_DATA[15:8].
// Optional sticky press latches when C1_PRESS_LATCH_EN is defined.
module c1_input_sampler
  import c1_inputs_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned BTN_W       = 10,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic                         CLK,
  input  logic                         nRESET,
  input  logic                         CE,
  input  logic [NUM_PLAYERS*BTN_W-1:0] P_IN,
  input  logic [NUM_PLAYERS-1:0]       nCTRL_ZONE,
  input  logic                         nSTATUSB_ZONE,
  input  logic                         nWP,
  input  logic                         nCD2,
  input  logic                         nCD1,
  input  logic                         SYSTEM_MODE,
  output logic [7:0]                   M68K_DATA,
  output logic                         DATA_OE
);

  logic [BTN_W-1:0] stable [NUM_PLAYERS];
  logic [BTN_W-1:0] press  [NUM_PLAYERS];
  logic [7:0]       ctrl_byte [NUM_PLAYERS];
  logic [7:0]       status_byte;

  // {SYSTEM_MODE, nWP, nCD2, nCD1}
  logic [3:0] misc_s1_q, misc_s2_q;

  logic [7:0] data_q, data_d;
  logic       oe_q, oe_d;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_chan
    c1_debounce #(
      .BTN_W      (BTN_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
      .clk_i    (CLK),
      .rst_ni   (nRESET),
      .ce_i     (CE),
      .raw_i    (P_IN[p*BTN_W +: BTN_W]),
      .stable_o (stable[p]),
      .press_o  (press[p])
    );
    // Not every channel bit reaches the bus (upper bits of players 2+, press in plain builds).
    logic unused_bits;
    assign unused_bits = ^{stable[p], press[p]};
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      misc_s1_q <= '1;
      misc_s2_q <= '1;
    end else begin
      misc_s1_q <= {SYSTEM_MODE, nWP, nCD2, nCD1};
      misc_s2_q <= misc_s1_q;
    end
  end

  always_comb begin
    status_byte                 = RELEASED_BYTE;
    status_byte[StbMode]        = misc_s2_q[3];
    status_byte[StbNwp]         = misc_s2_q[2];
    status_byte[StbNcd2]        = misc_s2_q[1];
    status_byte[StbNcd1]        = misc_s2_q[0];
    status_byte[StbP1Lo +: 2]   = stable[1][9:8];
    status_byte[StbP0Lo +: 2]   = stable[0][9:8];
  end

`ifdef C1_PRESS_LATCH_EN
  logic [7:0]             sticky_q [NUM_PLAYERS];
  logic [7:0]             sticky_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] zone_q;

  always_comb begin
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      // Clear at end of read; a press in the same cycle still sets.
      sticky_d[p]  = ((~zone_q[p] & nCTRL_ZONE[p]) ? 8'h00 : sticky_q[p]) | press[p][7:0];
      ctrl_byte[p] = stable[p][7:0] & ~sticky_q[p];
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      zone_q <= '1;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) sticky_q[p] <= '0;
    end else begin
      zone_q <= nCTRL_ZONE;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) sticky_q[p] <= sticky_d[p];
    end
  end
`else
  always_comb begin
    for (int p = 0; p < int'(NUM_PLAYERS); p++) ctrl_byte[p] = stable[p][7:0];
  end
`endif

  // Lowest CTRL index wins among overlapping zones; STATUS_B beats all of them.
  always_comb begin
    oe_d   = ~nSTATUSB_ZONE | ~&nCTRL_ZONE;
    data_d = RELEASED_BYTE;
    for (int p = int'(NUM_PLAYERS) - 1; p >= 0; p--) begin
      if (!nCTRL_ZONE[p]) data_d = ctrl_byte[p];
    end
    if (!nSTATUSB_ZONE) data_d = status_byte;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      data_q <= RELEASED_BYTE;
      oe_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      oe_q   <= oe_d;
    end
  end

  assign M68K_DATA = data_q;
  assign DATA_OE   = oe_q;

endmodule

// File: tb/tb_c1_input_sampler.sv
// Directed bench for c1_input_sampler: 2 players, 10 bits, 4-tick debounce, CE every 8 CLK.
module tb_c1_input_sampler;

  localparam int unsigned NP = 2;
  localparam int unsigned BW = 10;
  localparam int unsigned DC = 4;

`ifdef C1_PRESS_LATCH_EN
  localparam logic [7:0] ExpLatchRead = 8'hF7;
`else
  localparam logic [7:0] ExpLatchRead = 8'hFF;
`endif

  logic             CLK = 1'b0;
  logic             nRESET;
  logic             CE;
  logic [NP*BW-1:0] P_IN;
  logic [NP-1:0]    nCTRL_ZONE;
  logic             nSTATUSB_ZONE;
  logic             nWP, nCD2, nCD1, SYSTEM_MODE;
  logic [7:0]       M68K_DATA;
  logic             DATA_OE;

  int n_checks = 0;
  int n_pass   = 0;
  int ce_seen  = 0;

  c1_input_sampler #(
    .NUM_PLAYERS (NP),
    .BTN_W       (BW),
    .DEB_CYCLES  (DC)
  ) dut (
    .CLK           (CLK),
    .nRESET        (nRESET),
    .CE            (CE),
    .P_IN          (P_IN),
    .nCTRL_ZONE    (nCTRL_ZONE),
    .nSTATUSB_ZONE (nSTATUSB_ZONE),
    .nWP           (nWP),
    .nCD2          (nCD2),
    .nCD1          (nCD1),
    .SYSTEM_MODE   (SYSTEM_MODE),
    .M68K_DATA     (M68K_DATA),
    .DATA_OE       (DATA_OE)
  );

  always #5 CLK = ~CLK;

  initial begin
    CE = 1'b0;
    forever begin
      repeat (7) @(negedge CLK);
      CE = 1'b1;
      @(negedge CLK);
      CE = 1'b0;
    end
  end

  always @(posedge CLK) if (CE) ce_seen <= ce_seen + 1;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h, want %02h", tag, obs, exp);
  endtask

  task automatic wait_ces(input int n);
    int target;
    int budget;
    target = ce_seen + n;
    budget = 0;
    while (ce_seen < target && budget < 16 * n + 16) begin
      @(negedge CLK);
      budget++;
    end
    if (ce_seen < target) check_eq("ce_timeout", 8'(ce_seen), 8'(target));
  endtask

  task automatic read_zone(input logic [NP-1:0] ctrl_n, input logic stb_n,
                           output logic [7:0] data, output logic oe);
    @(negedge CLK);
    nCTRL_ZONE    = ctrl_n;
    nSTATUSB_ZONE = stb_n;
    @(negedge CLK);
    data          = M68K_DATA;
    oe            = DATA_OE;
    nCTRL_ZONE    = '1;
    nSTATUSB_ZONE = 1'b1;
  endtask

  logic [7:0] rd;
  logic       oe;

  initial begin
    nRESET        = 1'b0;
    P_IN          = '1;
    nCTRL_ZONE    = '1;
    nSTATUSB_ZONE = 1'b1;
    nWP           = 1'b1;
    nCD2          = 1'b1;
    nCD1          = 1'b1;
    SYSTEM_MODE   = 1'b0;

    // 1. Reset state, first read, reset mid-read
    repeat (3) @(negedge CLK);
    check_eq("rst_oe", {7'd0, DATA_OE}, 8'h00);
    check_eq("rst_data", M68K_DATA, 8'hFF);
    nRESET = 1'b1;
    @(negedge CLK);
    nCTRL_ZONE = 2'b10;
    @(negedge CLK);
    check_eq("rd0_oe", {7'd0, DATA_OE}, 8'h01);
    check_eq("rd0_data", M68K_DATA, 8'hFF);
    nRESET = 1'b0;
    #1;
    check_eq("midrst_oe", {7'd0, DATA_OE}, 8'h00);
    check_eq("midrst_data", M68K_DATA, 8'hFF);
    @(negedge CLK);
    nCTRL_ZONE = '1;
    nRESET     = 1'b1;

    // 2. Steady press accepted on the 4th CE, not the 3rd
    wait_ces(1);
    P_IN[0] = 1'b0;
    wait_ces(3);
    read_zone(2'b10, 1'b1, rd, oe);
    check_eq("deb_ce3", rd, 8'hFF);
    wait_ces(1);
    read_zone(2'b10, 1'b1, rd, oe);
    check_eq("deb_ce4", rd, 8'hFE);
    P_IN[0] = 1'b1;
    wait_ces(5);
    read_zone(2'b10, 1'b1, rd, oe);
    check_eq("deb_release", rd, 8'hFF);

    // 3. Bounce every 5 CLK is rejected
    @(negedge CLK);
    nCTRL_ZONE = 2'b10;
    for (int i = 0; i < 20; i++) begin
      repeat (5) @(negedge CLK);
      check_eq("bounce_rd", M68K_DATA, 8'hFF);
      P_IN[0] = ~P_IN[0];
    end
    nCTRL_ZONE = '1;
    wait_ces(5);
    read_zone(2'b10, 1'b1, rd, oe);
    check_eq("bounce_settle", rd, 8'hFF);

    // 4. STATUS_B assembly
    P_IN[9:8]   = 2'b01;
    P_IN[19:18] = 2'b10;
    nWP         = 1'b0;
    SYSTEM_MODE = 1'b1;
    wait_ces(5);
    read_zone(2'b11, 1'b0, rd, oe);
    check_eq("stb_a", rd, 8'hB9);
    check_eq("stb_a_oe", {7'd0, oe}, 8'h01);
    nWP         = 1'b1;
    nCD1        = 1'b0;
    SYSTEM_MODE = 1'b0;
    repeat (4) @(negedge CLK);
    read_zone(2'b11, 1'b0, rd, oe);
    check_eq("stb_b", rd, 8'h69);

    // 5. Overlapping zones and idle bus
    read_zone(2'b01, 1'b0, rd, oe);
    check_eq("ovl_stb_c1", rd, 8'h69);
    P_IN[15] = 1'b0;
    wait_ces(5);
    read_zone(2'b01, 1'b1, rd, oe);
    check_eq("ctrl1", rd, 8'hDF);
    read_zone(2'b00, 1'b1, rd, oe);
    check_eq("ovl_c0_c1", rd, 8'hFF);
    check_eq("ovl_c0_c1_oe", {7'd0, oe}, 8'h01);
    read_zone(2'b00, 1'b0, rd, oe);
    check_eq("ovl_all", rd, 8'h69);
    @(negedge CLK);
    check_eq("idle_oe", {7'd0, DATA_OE}, 8'h00);
    check_eq("idle_data", M68K_DATA, 8'hFF);
    P_IN[15] = 1'b1;
    wait_ces(5);
    read_zone(2'b01, 1'b1, rd, oe);
    check_eq("ctrl1_rel", rd, 8'hFF);

    // 6. Short press between polls
    P_IN[13] = 1'b0;
    wait_ces(5);
    P_IN[13] = 1'b1;
    wait_ces(5);
    read_zone(2'b01, 1'b1, rd, oe);
    check_eq("latch_rd1", rd, ExpLatchRead);
    read_zone(2'b01, 1'b1, rd, oe);
    check_eq("latch_rd2", rd, 8'hFF);

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish (%0d/%0d)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
